// File: rtl/counter_cmd_seq.sv
// Command sequencer driving the up/down counter's en/m/load/data_in.
// Each accepted command becomes a registered, cycle-exact control pattern, followed by a done pulse.
module counter_cmd_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    output logic             en,
    output logic             m,
    output logic             load,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [WIDTH-1:0] remaining
);

    typedef enum logic [1:0] {IDLE, EXEC, FIN} state_t;
    typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_HOLD = 2'b11} op_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic             accept;
    op_t              acc_op;
    logic [WIDTH-1:0] acc_cnt;
    logic             acc_en;
    logic             acc_m;
    logic             acc_load;

    assign cmd_ready = (state != EXEC) && !abort;
    assign accept    = cmd_valid && cmd_ready;
    // cnt is forced to 0 whenever EXEC is left, so it doubles as the remaining-cycles output
    assign remaining = cnt;

    always_comb begin
        acc_op   = op_t'(cmd_op);
        acc_cnt  = cmd_arg;
        acc_en   = 1'b0;
        acc_m    = 1'b0;
        acc_load = 1'b0;
        case (acc_op)
            OP_LOAD: begin
                acc_cnt  = WIDTH'(1);
                acc_load = 1'b1;
            end
            OP_UP:   acc_en = 1'b1;
            OP_DOWN: begin
                acc_en = 1'b1;
                acc_m  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            en      <= 1'b0;
            m       <= 1'b0;
            load    <= 1'b0;
            data_in <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    aborted <= 1'b0;
                    if (accept) begin
                        if (acc_op == OP_LOAD) data_in <= cmd_arg;
                        cnt <= acc_cnt;
                        if (acc_cnt != '0) begin
                            state <= EXEC;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            en    <= acc_en;
                            m     <= acc_m;
                            load  <= acc_load;
                        end else begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            en    <= 1'b0;
                            m     <= 1'b0;
                            load  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        en    <= 1'b0;
                        m     <= 1'b0;
                        load  <= 1'b0;
                    end
                end
                EXEC: begin
                    if (cnt == WIDTH'(1) || abort) begin
                        state   <= FIN;
                        cnt     <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= abort;
                        en      <= 1'b0;
                        m       <= 1'b0;
                        load    <= 1'b0;
                    end else begin
                        cnt <= cnt - WIDTH'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    aborted <= 1'b0;
                    en      <= 1'b0;
                    m       <= 1'b0;
                    load    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Scoreboard bench for counter_cmd_seq: driver pushes expected per-command results, monitor checks each cycle and at done.
// A small up/down counter stub consumes the sequencer outputs so the net count effect can be checked.
module tb_counter_cmd_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       abort;
    logic       en, m, load, busy, done, aborted;
    logic [7:0] data_in, remaining;

    counter_cmd_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .en(en), .m(m), .load(load),
        .data_in(data_in), .busy(busy), .done(done), .aborted(aborted), .remaining(remaining)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // downstream counter stub
    logic [7:0] ctr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ctr <= '0;
        else if (load) ctr <= data_in;
        else if (en)   ctr <= m ? ctr - 8'd1 : ctr + 8'd1;
    end

    typedef struct {
        int         op;
        int         cnt0;
        int         neff;
        bit         ab;
        int         acc;
        logic [7:0] din;
        logic [7:0] ctr;
    } rec_t;

    rec_t       q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] din_exp = '0;
    logic [7:0] ctr_exp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Issues one command; ab_at>0 raises abort so it is sampled at the edge ending active cycle ab_at.
    // Returns at a negedge: inside FIN for an unaborted command (next command then goes back-to-back).
    task automatic run_cmd(input int op, input int arg, input int ab_at, input bit ab_hold);
        int   cnt0, neff, ab_eff, tmo;
        rec_t r;
        cmd_op    = op[1:0];
        cmd_arg   = arg[7:0];
        cmd_valid = 1'b1;
        abort     = 1'b0;
        #1;
        tmo = 0;
        while (!cmd_ready && tmo < 50) begin
            @(negedge clk);
            #1;
            tmo++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'd1, 32'd0);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cnt0   = (op == 0) ? 1 : arg;
        ab_eff = (ab_at > 0 && ab_at <= cnt0) ? ab_at : 0;
        neff   = (ab_eff > 0) ? ab_eff : cnt0;
        case (op)
            0: begin
                din_exp = arg[7:0];
                ctr_exp = arg[7:0];
            end
            1: ctr_exp = ctr_exp + 8'(neff);
            2: ctr_exp = ctr_exp - 8'(neff);
            default: ;
        endcase
        r.op = op; r.cnt0 = cnt0; r.neff = neff; r.ab = (ab_eff > 0); r.acc = cyc;
        r.din = din_exp; r.ctr = ctr_exp;
        q.push_back(r);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_arg   = 8'($urandom_range(0, 255));
        if (ab_eff > 0) begin
            repeat (ab_eff - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            if (ab_hold) begin
                #1;
                chk("ready_blocked_in_fin", 32'(cmd_ready), 32'd0);
                @(negedge clk);
            end
            abort = 1'b0;
        end else begin
            repeat (neff) @(negedge clk);
        end
    endtask

    task automatic idle(input int k, input bit poke);
        cmd_valid = 1'b0;
        repeat (k) begin
            abort = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        abort = 1'b0;
    endtask

    // monitor
    initial begin
        int   n_up, n_dn, n_ld, n_hold, n_bad;
        rec_t r;
        n_up = 0; n_dn = 0; n_ld = 0; n_hold = 0; n_bad = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                n_up = 0; n_dn = 0; n_ld = 0; n_hold = 0; n_bad = 0;
                continue;
            end
            if (busy) begin
                if (q.size() == 0) chk("busy_without_cmd", 32'd1, 32'd0);
                else chk("remaining", 32'(remaining), 32'(q[0].cnt0 - (cyc - q[0].acc)));
                if (load && !en && !m)      n_ld++;
                else if (en && !m && !load) n_up++;
                else if (en && m && !load)  n_dn++;
                else if (!en && !m && !load) n_hold++;
                else                         n_bad++;
                if (done || aborted) n_bad++;
            end else begin
                chk("inactive_outputs", {28'd0, en, m, load, (remaining != 8'd0)}, 32'd0);
                if (!done) chk("aborted_without_done", 32'(aborted), 32'd0);
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("done_without_cmd", 32'd1, 32'd0);
                end else begin
                    r = q.pop_front();
                    chk("done_latency", 32'(cyc - r.acc), 32'(r.neff));
                    chk("aborted_flag", 32'(aborted), 32'(r.ab));
                    chk("load_cycles", 32'(n_ld), (r.op == 0) ? 32'(r.neff) : 32'd0);
                    chk("up_cycles", 32'(n_up), (r.op == 1) ? 32'(r.neff) : 32'd0);
                    chk("down_cycles", 32'(n_dn), (r.op == 2) ? 32'(r.neff) : 32'd0);
                    chk("hold_cycles", 32'(n_hold), (r.op == 3) ? 32'(r.neff) : 32'd0);
                    chk("bad_output_cycles", 32'(n_bad), 32'd0);
                    chk("data_in", 32'(data_in), 32'(r.din));
                    chk("counter_value", 32'(ctr), 32'(r.ctr));
                end
                n_up = 0; n_dn = 0; n_ld = 0; n_hold = 0; n_bad = 0;
            end
        end
    end

    initial begin
        rec_t r;
        int   op, arg, cnt0, ab, tmo;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0; abort = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {23'd0, en, m, load, busy, done, aborted, 3'd0}, 32'd0);
        chk("reset_data_in", 32'(data_in), 32'd0);
        chk("reset_remaining", 32'(remaining), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        // reset in the middle of UP 10: command is discarded, no done
        cmd_op = 2'd1; cmd_arg = 8'd10; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        r.op = 1; r.cnt0 = 10; r.neff = 10; r.ab = 1'b0; r.acc = cyc; r.din = din_exp; r.ctr = ctr_exp + 8'd10;
        q.push_back(r);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {25'd0, en, m, load, busy, done, aborted, (remaining != 8'd0)}, 32'd0);
        q.delete();
        ctr_exp = '0;
        din_exp = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_mid_reset", 32'(cmd_ready), 32'd1);
        idle(3, 1'b0);

        run_cmd(0, 5, 0, 1'b0);
        run_cmd(1, 3, 0, 1'b0);
        run_cmd(2, 4, 0, 1'b0);
        idle(2, 1'b1);
        run_cmd(1, 0, 0, 1'b0);
        run_cmd(3, 0, 0, 1'b0);
        run_cmd(1, 200, 2, 1'b1);
        idle(1, 1'b0);
        run_cmd(3, 255, 0, 1'b0);
        run_cmd(0, 255, 0, 1'b0);
        run_cmd(1, 1, 0, 1'b0);
        idle(2, 1'b1);
        run_cmd(2, 3, 3, 1'b0);
        run_cmd(0, 7, 1, 1'b1);
        run_cmd(2, 6, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op   = $urandom_range(0, 3);
            arg  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20);
            cnt0 = (op == 0) ? 1 : arg;
            ab   = ($urandom_range(0, 3) == 0 && cnt0 > 0) ? $urandom_range(1, cnt0) : 0;
            run_cmd(op, arg, ab, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3), 1'b1);
        end

        tmo = 0;
        while (q.size() != 0 && tmo < 300) begin
            @(negedge clk);
            tmo++;
        end
        chk("drain_pending", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
